// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers.
// Define MDU_FAST_MULT_EN for a single-cycle multiply path.
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  input  logic             HiWe,
  input  logic             LoWe,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_dz;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_b;

  logic               w_sa;
  logic               w_sb;
  logic [WIDTH-1:0]   w_ma;
  logic [WIDTH-1:0]   w_mb;
  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_trial;
  logic [2*WIDTH-1:0] w_div_nxt;
  logic [2*WIDTH-1:0] w_step;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_q;
  logic [WIDTH-1:0]   w_r;
  logic [WIDTH-1:0]   w_qm;
  logic [WIDTH-1:0]   w_rm;

  assign w_sa = ~Op[0] & OpA[WIDTH-1];
  assign w_sb = ~Op[0] & OpB[WIDTH-1];
  assign w_ma = w_sa ? (~OpA + 1'b1) : OpA;
  assign w_mb = w_sb ? (~OpB + 1'b1) : OpB;

  // Multiply: acc = {partial, multiplier}; add into upper half then shift.
  assign w_add = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
               + {1'b0, (r_acc[0] ? r_b : '0)};

  // Divide: acc = {remainder, quotient/dividend}; trial-subtract each step.
  assign w_trial = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_b};
  assign w_div_nxt = w_trial[WIDTH]
    ? {r_acc[2*WIDTH-2:0], 1'b0}
    : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  assign w_step = r_div ? w_div_nxt : {w_add, r_acc[WIDTH-1:1]};

  assign w_prod = r_neg_q ? (~r_acc + 1'b1) : r_acc;
  assign w_qm = r_acc[WIDTH-1:0];
  assign w_rm = r_acc[2*WIDTH-1:WIDTH];
  assign w_q = r_neg_q ? (~w_qm + 1'b1) : w_qm;
  assign w_r = r_neg_r ? (~w_rm + 1'b1) : w_rm;

`ifdef MDU_FAST_MULT_EN
  logic [2*WIDTH-1:0] w_fprod;
  assign w_fprod = (2*WIDTH)'(w_ma) * (2*WIDTH)'(w_mb);
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
      r_acc   <= '0;
      r_b     <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      DivZero <= 1'b0;
      Hi      <= '0;
      Lo      <= '0;
    end else begin
      Done    <= 1'b0;
      DivZero <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (Start) begin
            r_div   <= Op[1];
            r_neg_q <= w_sa ^ w_sb;
            r_neg_r <= w_sa;
            r_b     <= w_mb;
            r_cnt   <= '0;
            Busy    <= 1'b1;
            if (Op[1] && (OpB == '0)) begin
              r_dz    <= 1'b1;
              r_acc   <= {OpA, {WIDTH{1'b1}}};
              r_state <= FIX;
            end else begin
              r_dz    <= 1'b0;
`ifdef MDU_FAST_MULT_EN
              if (!Op[1]) begin
                r_acc   <= w_fprod;
                r_state <= FIX;
              end else begin
                r_acc   <= {{WIDTH{1'b0}}, w_ma};
                r_state <= RUN;
              end
`else
              r_acc   <= {{WIDTH{1'b0}}, w_ma};
              r_state <= RUN;
`endif
            end
          end else begin
            if (HiWe) Hi <= OpA;
            if (LoWe) Lo <= OpA;
          end
        end
        RUN: begin
          r_acc <= w_step;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(WIDTH-1)) r_state <= FIX;
        end
        FIX: begin
          Busy    <= 1'b0;
          Done    <= 1'b1;
          DivZero <= r_dz;
          r_cnt   <= '0;
          r_state <= IDLE;
          if (r_dz) begin
            {Hi, Lo} <= r_acc;
          end else if (r_div) begin
            Hi <= w_r;
            Lo <= w_q;
          end else begin
            {Hi, Lo} <= w_prod;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit.
// Covers mult/div latency, signs, div-by-zero, HI/LO writes, reset.
module tb_mul_div_unit;

  logic        Clk;
  logic        Reset_n;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] OpA;
  logic [31:0] OpB;
  logic        HiWe;
  logic        LoWe;
  logic        Busy;
  logic        Done;
  logic        DivZero;
  logic [31:0] Hi;
  logic [31:0] Lo;

  int total = 0;
  int bad   = 0;

`ifdef MDU_FAST_MULT_EN
  localparam int MLAT = 1;
`else
  localparam int MLAT = 33;
`endif

  localparam logic [1:0] MULT  = 2'b00;
  localparam logic [1:0] MULTU = 2'b01;
  localparam logic [1:0] DIV   = 2'b10;
  localparam logic [1:0] DIVU  = 2'b11;

  mul_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .Start   (Start),
    .Op      (Op),
    .OpA     (OpA),
    .OpB     (OpB),
    .HiWe    (HiWe),
    .LoWe    (LoWe),
    .Busy    (Busy),
    .Done    (Done),
    .DivZero (DivZero),
    .Hi      (Hi),
    .Lo      (Lo)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; drives request for exactly one clock edge.
  task automatic start_op(input logic [1:0] op,
                          input logic [31:0] a,
                          input logic [31:0] b);
    Start = 1'b1;
    Op    = op;
    OpA   = a;
    OpB   = b;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  // Counts negedges after acceptance until Done, bounded.
  task automatic wait_done(output int lat, output int busyc);
    lat   = 0;
    busyc = 0;
    while (!Done && lat < 100) begin
      if (Busy) busyc++;
      @(negedge Clk);
      lat++;
    end
  endtask

  task automatic run(input string tag,
                     input logic [1:0] op,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input int elat,
                     input logic [31:0] ehi,
                     input logic [31:0] elo,
                     input logic edz);
    int lat;
    int busyc;
    start_op(op, a, b);
    wait_done(lat, busyc);
    check({tag, "_lat"}, 32'(lat), 32'(elat));
    check({tag, "_busy"}, 32'(busyc), 32'(elat));
    check({tag, "_done"}, {31'd0, Done}, 32'd1);
    check({tag, "_bsy0"}, {31'd0, Busy}, 32'd0);
    check({tag, "_dz"}, {31'd0, DivZero}, {31'd0, edz});
    check({tag, "_hi"}, Hi, ehi);
    check({tag, "_lo"}, Lo, elo);
  endtask

  initial begin
    int lat;
    int busyc;
    int ndone;

    Reset_n = 1'b0;
    Start   = 1'b0;
    Op      = 2'b00;
    OpA     = '0;
    OpB     = '0;
    HiWe    = 1'b0;
    LoWe    = 1'b0;
    repeat (2) @(negedge Clk);
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_done", {31'd0, Done}, 32'd0);
    check("rst_dz", {31'd0, DivZero}, 32'd0);
    check("rst_hi", Hi, 32'd0);
    check("rst_lo", Lo, 32'd0);
    Reset_n = 1'b1;
    @(negedge Clk);

    run("mult", MULT, 32'd7, 32'hFFFFFFFD, MLAT,
        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    @(negedge Clk);
    check("mult_pulse", {31'd0, Done}, 32'd0);

    run("multu", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, MLAT,
        32'hFFFFFFFE, 32'h00000001, 1'b0);
    run("div", DIV, 32'hFFFFFFF9, 32'd2, 33,
        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run("ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 33,
        32'h00000000, 32'h80000000, 1'b0);
    run("divz", DIVU, 32'd100, 32'd0, 1,
        32'h00000064, 32'hFFFFFFFF, 1'b1);
    @(negedge Clk);
    check("divz_pulse", {31'd0, DivZero}, 32'd0);

    HiWe = 1'b1;
    OpA  = 32'h12345678;
    @(negedge Clk);
    HiWe = 1'b0;
    check("mthi", Hi, 32'h12345678);
    LoWe = 1'b1;
    OpA  = 32'hCAFEBABE;
    @(negedge Clk);
    LoWe = 1'b0;
    check("mtlo", Lo, 32'hCAFEBABE);
    check("mtlo_hi", Hi, 32'h12345678);

    // Disturb a DIVU in flight with HiWe, LoWe, Start and operand changes.
    start_op(DIVU, 32'd1000, 32'd7);
    repeat (5) @(negedge Clk);
    HiWe  = 1'b1;
    LoWe  = 1'b1;
    Start = 1'b1;
    Op    = MULT;
    OpA   = 32'hDEADBEEF;
    OpB   = 32'd5;
    @(negedge Clk);
    HiWe  = 1'b0;
    LoWe  = 1'b0;
    Start = 1'b0;
    check("busy_hi", Hi, 32'h12345678);
    check("busy_lo", Lo, 32'hCAFEBABE);
    wait_done(lat, busyc);
    check("dist_lat", 32'(lat + 6), 32'd33);
    check("dist_hi", Hi, 32'd6);
    check("dist_lo", Lo, 32'h0000008E);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (Done) ndone++;
    end
    check("dist_single", 32'(ndone), 32'd0);

    // Back-to-back: Start issued in the Done cycle.
    start_op(MULTU, 32'd3, 32'd5);
    wait_done(lat, busyc);
    check("b2b1_lo", Lo, 32'd15);
    start_op(MULTU, 32'd6, 32'd7);
    wait_done(lat, busyc);
    check("b2b2_lat", 32'(lat), 32'(MLAT));
    check("b2b2_hi", Hi, 32'd0);
    check("b2b2_lo", Lo, 32'd42);

    // Asynchronous reset mid-divide.
    start_op(DIV, 32'hFFFFFF9C, 32'd7);
    repeat (9) @(negedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    check("mrst_busy", {31'd0, Busy}, 32'd0);
    check("mrst_hi", Hi, 32'd0);
    check("mrst_lo", Lo, 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (Done) ndone++;
    end
    check("mrst_nodone", 32'(ndone), 32'd0);
    run("rediv", DIV, 32'hFFFFFF9C, 32'd7, 33,
        32'hFFFFFFFE, 32'hFFFFFFF2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
